// File: rtl/ring_seq_counter_if.sv
// rtl/ring_seq_counter_if.sv - control and status bundle for the ring/Johnson sequence counter
interface ring_seq_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             dir;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             err;

    modport master (
        output en, dir, mode, load, d,
        input  q, tc, err
    );

    modport slave (
        input  en, dir, mode, load, d,
        output q, tc, err
    );
endinterface

// File: rtl/ring_seq_counter.sv
// rtl/ring_seq_counter.sv - ring/Johnson sequence counter; RING_SELFCORRECT_EN enables illegal-state correction
module ring_seq_counter #(
    parameter int WIDTH = 4
) (
    input  logic               c,
    input  logic               rst,
    ring_seq_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] RING_HOME = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] adv;
    logic [WIDTH-1:0] home_cur;
    logic             mode_q;
    logic             tc_r;
    logic             tc_nxt;
    logic             err_r;
    logic             err_nxt;

    function automatic logic [WIDTH-1:0] home_of(input logic m);
        return m ? '0 : RING_HOME;
    endfunction

    assign home_cur = home_of(mode_q);

    always_comb begin
        adv = q_r;
        if (!mode_q) begin
            adv = bus.dir ? {q_r[0], q_r[WIDTH-1:1]} : {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        end else begin
            adv = bus.dir ? {~q_r[0], q_r[WIDTH-1:1]} : {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
        end
    end

`ifdef RING_SELFCORRECT_EN
    localparam logic [WIDTH-2:0] T_ONE = {{(WIDTH-2){1'b0}}, 1'b1};

    logic [WIDTH-2:0] trans;
    logic             ring_legal;
    logic             john_legal;
    logic             cur_legal;

    // A Johnson state is legal when adjacent bits differ in at most one place.
    always_comb begin
        trans      = q_r[WIDTH-1:1] ^ q_r[WIDTH-2:0];
        ring_legal = (q_r != '0) && ((q_r & (q_r - RING_HOME)) == '0);
        john_legal = ((trans & (trans - T_ONE)) == '0);
        cur_legal  = mode_q ? john_legal : ring_legal;
    end
`endif

    always_comb begin
        q_nxt   = q_r;
        tc_nxt  = 1'b0;
        err_nxt = 1'b0;
        if (bus.mode != mode_q) begin
            q_nxt = home_of(bus.mode);
        end else if (bus.load) begin
            q_nxt = bus.d;
        end else if (bus.en) begin
            q_nxt  = adv;
            tc_nxt = (adv == home_cur);
`ifdef RING_SELFCORRECT_EN
            if (!cur_legal) begin
                q_nxt   = home_cur;
                tc_nxt  = 1'b0;
                err_nxt = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            q_r    <= home_of(bus.mode);
            mode_q <= bus.mode;
            tc_r   <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            mode_q <= bus.mode;
            tc_r   <= tc_nxt;
            err_r  <= err_nxt;
        end
    end

    assign bus.q   = q_r;
    assign bus.tc  = tc_r;
    assign bus.err = err_r;
endmodule

// File: doc/ring_seq_counter.md
RING_SEQ_COUNTER -- requirements
Module: ring_seq_counter

Interface
REQ-001 The block SHALL have one clock, c, and a synchronous, active-high reset, rst.
REQ-002 Parameter WIDTH, default 4, SHALL set the count register width; legal values are 2 to 32.
REQ-003 Port c SHALL be a 1-bit input that acts as the clock; all state SHALL update on its rising edge.
REQ-004 Port rst SHALL be a 1-bit input that acts as the synchronous active-high reset.
REQ-005 Port en SHALL be a 1-bit input that advances the sequence by one step when high.
REQ-006 Port dir SHALL be a 1-bit input selecting direction: 0 = up (shift toward MSB), 1 = down (shift toward LSB).
REQ-007 Port mode SHALL be a 1-bit input selecting the sequence: 0 = ring (one-hot), 1 = Johnson (twisted ring).
REQ-008 Port load SHALL be a 1-bit input requesting a parallel load of d.
REQ-009 Port d SHALL be a WIDTH-bit input carrying the parallel load value.
REQ-010 Port q SHALL be a WIDTH-bit registered output carrying the counter state.
REQ-011 Port tc SHALL be a 1-bit registered output that pulses for one cycle on sequence wrap.
REQ-012 Port err SHALL be a 1-bit registered output that pulses for one cycle when an illegal state is corrected.

Function
REQ-013 The home pattern SHALL be {0...01} (bit 0 set) in ring mode and all-zeros in Johnson mode.
REQ-014 Per-edge priority SHALL be: rst, then mode change, then load, then en advance, then hold.
REQ-015 A mode change SHALL be detected as mode differing from a registered copy of mode (mode_q); on that edge q SHALL take the new mode's home pattern, tc and err SHALL be 0, and any load or en on that edge SHALL be ignored.
REQ-016 On a load, q SHALL take d verbatim, and tc and err SHALL be 0.
REQ-017 A ring advance SHALL rotate q: up gives q <= {q[W-2:0], q[W-1]}; down gives q <= {q[0], q[W-1:1]}.
REQ-018 A Johnson advance SHALL shift q with inversion: up gives q <= {q[W-2:0], ~q[W-1]}; down gives q <= {~q[0], q[W-1:1]}.
REQ-019 When en=0 and no higher-priority event occurs, q SHALL hold its value and tc and err SHALL be 0.
REQ-020 tc SHALL be 1 in the cycle after an advance whose result equals the current mode's home pattern, and 0 otherwise; the period is WIDTH advances in ring mode and 2*WIDTH in Johnson mode.
REQ-021 A change of dir SHALL take effect on the same edge, with no extra latency and no reset of q.
REQ-022 A legal ring state SHALL have exactly one bit set; a legal Johnson state SHALL have the form 0..01..1 or 1..10..0, including all-zeros and all-ones.
REQ-023 Single-cycle latency: q SHALL reflect every control input on the edge at which that input is sampled.

Reset
REQ-024 When rst=1 at a rising edge of c, q SHALL take the home pattern of the mode sampled on that edge, mode_q SHALL take mode, and tc and err SHALL be 0.
REQ-025 Reset SHALL override load, en and a mode change asserted on the same edge.
REQ-026 Reset asserted mid-sequence SHALL abandon the current phase, with no tc pulse.

Configuration
REQ-027 Macro RING_SELFCORRECT_EN SHALL control illegal-state correction; only this feature SHALL be compiled in or out by a macro.
REQ-028 With RING_SELFCORRECT_EN defined, an en advance from an illegal state SHALL instead load the home pattern and pulse err for one cycle; tc SHALL NOT pulse on that edge.
REQ-029 Without RING_SELFCORRECT_EN, illegal patterns SHALL rotate or shift per REQ-017/REQ-018 unchanged, and err SHALL be tied to 0.

Verification (WIDTH=4)
REQ-030 Ring up: with mode=0, hold rst=1 for 3 cycles, then set en=1, dir=0 -> q SHALL read 0001, 0010, 0100, 1000, 0001, with tc=1 only in the cycle q returns to 0001.
REQ-031 Johnson up: with mode=1, rst, then en=1 -> q SHALL read 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, with tc=1 after the 8th advance.
REQ-032 Ring down from 0001 with dir=1 -> q SHALL read 1000, then 0100; switching dir to 0 mid-run SHALL give 1000 on the next edge.
REQ-033 Illegal load: load d=0110 with mode=0, then en=1 -> with the macro, q SHALL be 0001 and err=1 for one cycle; without the macro, q SHALL be 1100 and err=0.
REQ-034 Mode change: toggle mode 0->1 while q=0100 and en=1 -> the next q SHALL be 0000, with tc=0 and err=0.
REQ-035 Reset priority: assert rst together with load=1, d=1111 and en=1 mid-run -> q SHALL be the home pattern, with tc=0 and err=0.
